// File: rtl/button_debounce_if.sv
// Button conditioner signal bundle: raw pin towards the debouncer, clean level and pulses back.
interface button_debounce_if;
    logic button;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic long_press;

    modport master (output button, input btn_level, btn_press, btn_release, long_press);
    modport slave  (input button, output btn_level, btn_press, btn_release, long_press);
endinterface

// File: rtl/button_debounce.sv
// Push-button synchroniser + debouncer producing a clean level and press/release/long-press pulses.
// Long-press detection is present only when BUTTON_LONG_PRESS_EN is defined.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_CYCLES       = 50_000_000,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    button_debounce_if.slave bus
);
    localparam int unsigned     DW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]   D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic            PIN_IDLE = BUTTON_ACTIVE_LOW;

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("button_debounce: illegal DEBOUNCE_CYCLES / LONG_CYCLES");
    end

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic          sync1;
    logic          sync2;
    logic          btn_s;
    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nxt;
    logic          level_q;
    logic          level_nxt;
    logic          press_q;
    logic          press_nxt;
    logic          release_q;
    logic          release_nxt;
    logic          long_q;
    logic          long_nxt;

    // Two-flop synchroniser; reset parks both flops at the released pin level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= PIN_IDLE;
            sync2 <= PIN_IDLE;
        end else begin
            sync1 <= bus.button;
            sync2 <= sync1;
        end
    end

    assign btn_s = BUTTON_ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= RELEASED;
            dcnt      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            dcnt      <= dcnt_nxt;
            level_q   <= level_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            long_q    <= long_nxt;
        end
    end

    // Debounce FSM: an edge is accepted after DEBOUNCE_CYCLES stable samples in a CHK state
    always_comb begin
        state_nxt   = state;
        dcnt_nxt    = dcnt;
        level_nxt   = level_q;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            RELEASED: begin
                if (btn_s) begin
                    state_nxt = PRESS_CHK;
                    dcnt_nxt  = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    state_nxt = RELEASED;
                end else if (dcnt == D_LAST) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    dcnt_nxt = dcnt + DW'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_CHK;
                    dcnt_nxt  = '0;
                end
            end
            RELEASE_CHK: begin
                if (btn_s) begin
                    state_nxt = PRESSED;
                end else if (dcnt == D_LAST) begin
                    state_nxt   = RELEASED;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end else begin
                    dcnt_nxt = dcnt + DW'(1);
                end
            end
            default: state_nxt = RELEASED;
        endcase
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int unsigned   LW     = $clog2(LONG_CYCLES);
    localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] lcnt;
    logic [LW-1:0] lcnt_nxt;
    logic          long_done;
    logic          long_done_nxt;
    logic          held;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lcnt      <= '0;
            long_done <= 1'b0;
        end else begin
            lcnt      <= lcnt_nxt;
            long_done <= long_done_nxt;
        end
    end

    // Hold-time counter saturates at its terminal value; a release edge suppresses a coincident fire
    always_comb begin
        lcnt_nxt      = lcnt;
        long_done_nxt = long_done;
        long_nxt      = 1'b0;
        held          = (state == PRESSED) || (state == RELEASE_CHK);
        if (press_nxt) begin
            lcnt_nxt      = '0;
            long_done_nxt = 1'b0;
        end else if (held) begin
            if (lcnt == L_LAST) begin
                if (!long_done && !release_nxt) begin
                    long_nxt      = 1'b1;
                    long_done_nxt = 1'b1;
                end
            end else begin
                lcnt_nxt = lcnt + LW'(1);
            end
        end
    end
`else
    assign long_nxt = 1'b0;
`endif

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.long_press  = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios then random pin activity,
// compared every cycle against a run-length reference model of the debounce rules.
module tb_button_debounce;
    localparam int D = 4;
    localparam int L = 16;
`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    button_debounce_if bus ();

    button_debounce #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_CYCLES       (L),
        .BUTTON_ACTIVE_LOW (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: pressed samples reach the decision logic two edges late;
    // an edge is accepted after D+1 consecutive samples disagreeing with the current level.
    bit pin_q[$] = '{1'b0, 1'b0};
    bit m_level = 1'b0;
    int m_run = 0;
    int m_age = 0;
    bit e_press = 1'b0;
    bit e_release = 1'b0;
    bit e_long = 1'b0;

    int n_press = 0;
    int n_release = 0;
    int n_long = 0;
    int last_press_cyc = 0;
    int last_release_cyc = 0;
    int last_long_cyc = 0;
    bit level_at_long = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_edge();
        bit s;
        e_press   = 1'b0;
        e_release = 1'b0;
        e_long    = 1'b0;
        if (!reset_n) begin
            pin_q   = '{1'b0, 1'b0};
            m_level = 1'b0;
            m_run   = 0;
            m_age   = 0;
            return;
        end
        s = pin_q.pop_front();
        pin_q.push_back(!bus.button);
        if (s != m_level) m_run++;
        else m_run = 0;
        if (m_run == D + 1) begin
            m_level = s;
            m_run   = 0;
            m_age   = 0;
            if (s) e_press = 1'b1;
            else   e_release = 1'b1;
        end else if (m_level) begin
            m_age++;
            if (LONG_EN && m_age == L) e_long = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        chk("level",   bus.btn_level,   m_level);
        chk("press",   bus.btn_press,   e_press);
        chk("release", bus.btn_release, e_release);
        chk("long",    bus.long_press,  e_long);
        if (bus.btn_press === 1'b1)   begin n_press++;   last_press_cyc = cyc;   end
        if (bus.btn_release === 1'b1) begin n_release++; last_release_cyc = cyc; end
        if (bus.long_press === 1'b1) begin
            n_long++;
            last_long_cyc = cyc;
            level_at_long = bus.btn_level;
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_press(input string tag);
        int p0 = n_press;
        for (int k = 0; k < 50 && n_press == p0; k++) tick();
        chk(tag, int'(n_press != p0), 1);
    endtask

    task automatic wait_release(input string tag);
        int r0 = n_release;
        for (int k = 0; k < 50 && n_release == r0; k++) tick();
        chk(tag, int'(n_release != r0), 1);
    endtask

    initial begin
        int t0;
        int l0;
        int r0;
        int hold;

        // Reset with the pin released, then idle
        bus.button = 1'b1;
        reset_n    = 1'b0;
        tick_n(3);
        chk("reset_level", bus.btn_level, 0);
        reset_n = 1'b1;
        tick_n(20);
        chk("idle_press", n_press, 0);
        chk("idle_release", n_release, 0);

        // Short bounce must be rejected
        bus.button = 1'b0;
        tick_n(3);
        bus.button = 1'b1;
        tick_n(10);
        chk("bounce_press", n_press, 0);
        chk("bounce_level", bus.btn_level, 0);

        // Clean press and its latency
        bus.button = 1'b0;
        t0 = cyc + 1;
        wait_press("press_seen");
        chk("press_latency", last_press_cyc - t0, D + 2);
        chk("press_count", n_press, 1);

        // Long hold: single long_press L cycles after btn_press
        l0 = n_long;
        tick_n(40);
        chk("long_count", n_long - l0, LONG_EN ? 1 : 0);
        chk("long_delay", (n_long > l0) ? last_long_cyc - last_press_cyc : 0, LONG_EN ? L : 0);
        chk("long_level", level_at_long, LONG_EN ? 1 : 0);
        chk("level_held", bus.btn_level, 1);

        // Release glitch rejected, then real release
        bus.button = 1'b1;
        tick_n(2);
        bus.button = 1'b0;
        tick_n(10);
        chk("glitch_release", n_release, 0);
        bus.button = 1'b1;
        t0 = cyc + 1;
        wait_release("release_seen");
        chk("release_latency", last_release_cyc - t0, D + 2);
        tick();
        chk("level_after_release", bus.btn_level, 0);

        // Reset in the middle of a press
        bus.button = 1'b0;
        wait_press("press2_seen");
        tick_n(2);
        r0 = n_release;
        reset_n = 1'b0;
        tick();
        chk("reset_mid_level", bus.btn_level, 0);
        reset_n = 1'b1;
        t0 = cyc + 1;
        wait_press("repress_seen");
        chk("reset_no_release", n_release - r0, 0);
        chk("repress_latency", last_press_cyc - t0, 6);

        // Random pin activity with occasional single-cycle resets
        for (int seg = 0; seg < 150; seg++) begin
            bus.button = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            hold = int'($urandom_range(1, 24));
            tick_n(hold);
        end
        bus.button = 1'b1;
        tick_n(12);
        chk("final_level", bus.btn_level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
